// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the load/store initiator: access modes, FSM states
// and the alignment predicate reused by the data memory and hazard logic.
package lsu_mem_initiator_pkg;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } lsu_state_t;

    // True when the access cannot be served: reserved mode or an address
    // that is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] mode,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (mode)
            MODE_BYTE: bad = 1'b0;
            MODE_HALF: bad = addr_lo[0];
            MODE_WORD: bad = |addr_lo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it to 32 bits.
module lsu_load_align
    import lsu_mem_initiator_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  mode,
    input  logic        is_signed,
    output logic [31:0] ext
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // NOTE: every combinational output gets a default before the case, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        ext    = word;
        lane_b = word[7:0];
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];
        case (addr_lo)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        case (mode)
            MODE_BYTE: ext = {{24{is_signed & lane_b[7]}}, lane_b};
            MODE_HALF: ext = {{16{is_signed & lane_h[15]}}, lane_h};
            default:   ext = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator between the CPU memory stage and a
// word-organised data memory with a valid/ready request/response interface.
module lsu_mem_initiator
    import lsu_mem_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_mode,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [1:0]            mem_mode,
    output logic                  mem_str,
    output logic                  mem_sel,
    output logic                  mem_ld,
    input  logic [31:0]           mem_rdata
);

    lsu_state_t            state, state_next;
    logic                  we_q, signed_q;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           load_data;
    logic                  accept, misaligned;

    assign accept     = req_valid && req_ready;
    assign misaligned = is_misaligned(req_mode, req_addr[1:0]);

    lsu_load_align u_align (
        .word      (mem_rdata),
        .addr_lo   (addr_q[1:0]),
        .mode      (mode_q),
        .is_signed (signed_q),
        .ext       (load_data)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = misaligned ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Request fields and response data are only a handful of flops, so all
    // of them reset; an aborted access then leaves nothing stale on mem_*.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            mode_q    <= MODE_BYTE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            we_q      <= req_we;
            signed_q  <= req_signed;
            mode_q    <= req_mode;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= misaligned;
        end else if (state == ST_ISSUE && !we_q) begin
            rsp_rdata <= load_data;
        end
    end

    // Strobes decode straight from the state register, so an asynchronous
    // reset during ISSUE removes them before the next edge can write.
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign mem_sel   = (state == ST_ISSUE);
    assign mem_ld    = mem_sel;
    assign mem_str   = mem_sel && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_mode  = mode_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator with a behavioural word memory;
// inputs change and outputs are sampled on the falling clock edge.
module tb_lsu_mem_initiator;
    import lsu_mem_initiator_pkg::*;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          req_valid, req_ready, req_we, req_signed;
    logic [1:0]    req_mode;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [1:0]    mem_mode;
    logic          mem_str, mem_sel, mem_ld;

    logic [31:0] mem [0:1023];
    logic [32:0] sb_q [$];   // {err, rdata}
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .clr_n(clr_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mode(req_mode), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
        .mem_str(mem_str), .mem_sel(mem_sel), .mem_ld(mem_ld),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[AW-1:2]];

    // Memory places the right-aligned store data into the addressed lane.
    always @(posedge clk) begin
        if (mem_sel && mem_str) begin
            case (mem_mode)
                MODE_BYTE: mem[mem_addr[AW-1:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
                MODE_HALF: mem[mem_addr[AW-1:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
                default:   mem[mem_addr[AW-1:2]] <= mem_wdata;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the
    // response handshake. chain puts a word load at 0x010 on the request
    // port in the same cycle rsp_ready is raised.
    task automatic run_req(input logic we, input logic [1:0] mode, input logic sgn,
                           input logic [AW-1:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int hold, input logic chain);
        int          k;
        int          sel_cnt;
        bit          seen;
        logic [32:0] exp;
        req_valid = 1'b1; req_we = we; req_mode = mode; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        sb_q.push_back({exp_err, exp_rdata});
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        k = 1; sel_cnt = 0; seen = 0;
        while (!seen && k <= 10) begin
            if (mem_sel) begin
                sel_cnt++;
                check("mem_sel_slot", 32'(k), 32'd1);
                check("mem_ld", 32'(mem_ld), 32'd1);
                check("mem_str", 32'(mem_str), 32'(we));
                check("mem_addr", 32'(mem_addr), 32'(addr));
                check("mem_mode", 32'(mem_mode), 32'(mode));
                check("mem_wdata", mem_wdata, wdata);
            end
            if (rsp_valid) seen = 1;
            else begin
                check("req_ready_busy", 32'(req_ready), 32'd0);
                @(negedge clk);
                k++;
            end
        end
        if (!seen) begin
            check("rsp_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
            return;
        end
        check("latency", 32'(k), exp_err ? 32'd1 : 32'd2);
        check("mem_sel_count", 32'(sel_cnt), exp_err ? 32'd0 : 32'd1);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, sb_q[0][31:0]);
            check("hold_err", 32'(rsp_err), 32'(sb_q[0][32]));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        if (chain) begin
            req_valid = 1'b1; req_we = 1'b0; req_mode = MODE_WORD;
            req_signed = 1'b0; req_addr = 12'h010; req_wdata = '0;
        end
        exp = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, exp[31:0]);
        check("rsp_err", 32'(rsp_err), 32'(exp[32]));
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        mem[8] = 32'h11111111;
        clr_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_mode = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_ctl", {29'd0, mem_sel, mem_ld, mem_str}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_mode", 32'(mem_mode), 32'd0);
        @(negedge clk); @(negedge clk);
        clr_n = 1'b1;

        // Loads from the word 0x8899AABB at 0x010.
        run_req(0, MODE_BYTE, 1, 12'h012, 0, 32'hFFFFFF99, 0, 0, 0);
        run_req(0, MODE_HALF, 0, 12'h012, 0, 32'h00008899, 0, 0, 0);
        run_req(0, MODE_HALF, 1, 12'h010, 0, 32'hFFFFAABB, 0, 0, 0);
        run_req(0, MODE_WORD, 1, 12'h010, 0, 32'h8899AABB, 0, 0, 0);
        run_req(0, MODE_BYTE, 1, 12'h011, 0, 32'hFFFFFFAA, 0, 0, 0);
        run_req(0, MODE_BYTE, 0, 12'h000, 0, 32'h00000000, 0, 0, 0);

        // Byte store into lane 3, then read it back both ways.
        run_req(1, MODE_BYTE, 0, 12'h013, 32'h1234565A, 32'h0, 0, 0, 0);
        check("mem_after_store", mem[4], 32'h5A99AABB);
        run_req(0, MODE_BYTE, 0, 12'h013, 0, 32'h0000005A, 0, 0, 0);
        run_req(0, MODE_WORD, 0, 12'h010, 0, 32'h5A99AABB, 0, 0, 0);

        // Misaligned and reserved-mode requests.
        run_req(0, MODE_WORD, 0, 12'h011, 0, 32'h0, 1, 0, 0);
        run_req(0, MODE_HALF, 1, 12'h013, 0, 32'h0, 1, 0, 0);
        run_req(0, MODE_RSVD, 0, 12'h010, 0, 32'h0, 1, 0, 0);
        run_req(1, MODE_RSVD, 0, 12'h014, 32'hCAFEF00D, 32'h0, 1, 0, 0);
        check("mem_rsvd_store", mem[5], 32'h0);

        // Backpressure with a request waiting while the response drains.
        run_req(0, MODE_BYTE, 0, 12'h010, 0, 32'h000000BB, 0, 4, 1);
        run_req(0, MODE_WORD, 0, 12'h010, 0, 32'h5A99AABB, 0, 0, 0);

        // Reset during the ISSUE cycle of a word store.
        req_valid = 1'b1; req_we = 1'b1; req_mode = MODE_WORD; req_signed = 1'b0;
        req_addr = 12'h020; req_wdata = 32'hDEADBEEF;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check("abort_issue_sel", 32'(mem_sel), 32'd1);
        check("abort_issue_str", 32'(mem_str), 32'd1);
        #2 clr_n = 1'b0;
        #1;
        check("abort_sel_drop", 32'(mem_sel), 32'd0);
        check("abort_str_drop", 32'(mem_str), 32'd0);
        @(posedge clk); @(negedge clk);
        clr_n = 1'b1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_no_write", mem[8], 32'h11111111);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
